// File: rtl/ibex_bloom_unit_pkg.sv
// ---------------------------------------------------------------------------
// ibex_bloom_unit_pkg
// Shared types and constants for the Bloom-filter custom-instruction unit.
//   bloom_op_e    : custom-op encoding carried on op_i
//   bloom_state_e : control FSM states of ibex_bloom_unit
//   BLOOM_ROT     : left-rotate amount applied to key_a when forming h2
//   bloom_rotl    : 32-bit rotate-left helper
// ---------------------------------------------------------------------------
package ibex_bloom_unit_pkg;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_CHECK  = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_COUNT  = 2'd3
    } bloom_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HASH  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } bloom_state_e;

    localparam int unsigned BLOOM_ROT = 7;

    function automatic logic [31:0] bloom_rotl(input logic [31:0] x, input int unsigned sh);
        return (x << sh) | (x >> (32 - sh));
    endfunction

endpackage

// File: rtl/ibex_bloom_unit_if.sv
// ---------------------------------------------------------------------------
// ibex_bloom_unit_if
// Request/result bundle between the execute stage and the Bloom unit.
//   req_i    : request strobe, accepted only while ready_o=1
//   op_i     : bloom_op_e (INSERT, CHECK, CLEAR, COUNT)
//   key_a_i  : rs1 operand
//   key_b_i  : rs2 operand
//   kill_i   : pipeline flush from the controller
//   ready_o  : unit idle, can accept
//   valid_o  : one-cycle result pulse
//   result_o : 32-bit result, meaningful only with valid_o
//   busy_o   : ~ready_o
// Modports: master = execute stage side, slave = the unit.
// ---------------------------------------------------------------------------
interface ibex_bloom_unit_if;
    import ibex_bloom_unit_pkg::*;

    logic        req_i;
    bloom_op_e   op_i;
    logic [31:0] key_a_i;
    logic [31:0] key_b_i;
    logic        kill_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        busy_o;

    modport master (
        output req_i, op_i, key_a_i, key_b_i, kill_i,
        input  ready_o, valid_o, result_o, busy_o
    );

    modport slave (
        input  req_i, op_i, key_a_i, key_b_i, kill_i,
        output ready_o, valid_o, result_o, busy_o
    );

endinterface

// File: rtl/ibex_bloom_unit_hash.sv
// ---------------------------------------------------------------------------
// ibex_bloom_hash
// Combinational double-hashing front end of the Bloom unit.
//   key_a_i, key_b_i : request operands
//   h1_o             : first probe index
//   h2_o             : probe stride (always odd, so probes walk the whole array)
// Both outputs are the low log2(FilterBits) bits of the 32-bit hashes.
// ---------------------------------------------------------------------------
module ibex_bloom_hash
    import ibex_bloom_unit_pkg::*;
#(
    parameter int unsigned FilterBits = 1024
) (
    input  logic [31:0]                   key_a_i,
    input  logic [31:0]                   key_b_i,
    output logic [$clog2(FilterBits)-1:0] h1_o,
    output logic [$clog2(FilterBits)-1:0] h2_o
);
    localparam int unsigned IdxW = $clog2(FilterBits);

    logic [31:0] h1_full;
    logic [31:0] h2_full;

    assign h1_full = key_a_i ^ {key_b_i[15:0], key_b_i[31:16]};
    assign h2_full = (key_b_i ^ bloom_rotl(key_a_i, BLOOM_ROT)) | 32'd1;

    assign h1_o = h1_full[IdxW-1:0];
    assign h2_o = h2_full[IdxW-1:0];

    // Upper hash bits are architecturally discarded; fold them into a sink.
    logic unused_hi;
    assign unused_hi = ^{h1_full[31:IdxW], h2_full[31:IdxW]};

endmodule

// File: rtl/ibex_bloom_unit.sv
// ---------------------------------------------------------------------------
// ibex_bloom_unit
// Multi-cycle Bloom-filter functional unit for the execute stage.
// Holds a FilterBits-wide bit array and supports INSERT, CHECK, CLEAR, COUNT.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset (clears array and counters)
//   bus   : ibex_bloom_unit_if.slave (req/op/keys/kill in, ready/valid/result/busy out)
// Parameters: FilterBits (array size), NumHashes (probes per key),
//   ClearPerCycle (bits zeroed per CLEAR cycle).
// Optional: define IBEX_BLOOM_POPCOUNT_EN to add a 16-bit occupancy counter;
//   COUNT then returns {occupancy, insert count saturated to 16 bits}.
// ---------------------------------------------------------------------------
module ibex_bloom_unit
    import ibex_bloom_unit_pkg::*;
#(
    parameter int unsigned FilterBits    = 1024,
    parameter int unsigned NumHashes     = 3,
    parameter int unsigned ClearPerCycle = 32
) (
    input logic              clk_i,
    input logic              rst_i,
    ibex_bloom_unit_if.slave bus
);
    localparam int unsigned IdxW      = $clog2(FilterBits);
    localparam int unsigned NumChunks = FilterBits / ClearPerCycle;
    localparam int unsigned PtrW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam int unsigned KW        = 3;  // NumHashes <= 8, so k fits 0..7
    localparam logic [KW-1:0]   KLast   = KW'(NumHashes - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(NumChunks - 1);

    bloom_state_e        state_q, state_d;
    bloom_op_e           op_q, op_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     h2_q, h2_d;
    logic [KW-1:0]       k_q, k_d;
    logic                acc_q, acc_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic                kill_seen_q, kill_seen_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [FilterBits-1:0] filter_q, filter_d;
`ifdef IBEX_BLOOM_POPCOUNT_EN
    logic [15:0]         pc_q, pc_d;
`endif

    logic [IdxW-1:0] h1, h2;
    logic            accept;
    logic            probe_bit;
    logic [IdxW-1:0] clr_base;
    logic [31:0]     result;

    ibex_bloom_hash #(
        .FilterBits(FilterBits)
    ) u_hash (
        .key_a_i(bus.key_a_i),
        .key_b_i(bus.key_b_i),
        .h1_o   (h1),
        .h2_o   (h2)
    );

    // A kill in the same cycle as the request squashes the acceptance.
    assign accept    = bus.req_i & ~bus.kill_i & (state_q == ST_IDLE);
    assign probe_bit = filter_q[idx_q];
    assign clr_base  = IdxW'(ptr_q * ClearPerCycle);

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        h2_d        = h2_q;
        k_d         = k_q;
        acc_d       = acc_q;
        ptr_d       = ptr_q;
        kill_seen_d = kill_seen_q;
        cnt_d       = cnt_q;
        filter_d    = filter_q;
`ifdef IBEX_BLOOM_POPCOUNT_EN
        pc_d        = pc_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d        = bus.op_i;
                    kill_seen_d = 1'b0;
                    unique case (bus.op_i)
                        OP_INSERT, OP_CHECK: begin
                            state_d = ST_HASH;
                            idx_d   = h1;
                            h2_d    = h2;
                            k_d     = '0;
                            acc_d   = 1'b1;
                        end
                        OP_CLEAR: begin
                            state_d = ST_CLEAR;
                            ptr_d   = '0;
                            cnt_d   = '0;
`ifdef IBEX_BLOOM_POPCOUNT_EN
                            pc_d    = '0;
`endif
                        end
                        OP_COUNT: state_d = ST_DONE;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end

            ST_HASH: begin
                // A flushed probe does not read or write; earlier probes stand.
                if (bus.kill_i) begin
                    state_d = ST_IDLE;
                end else begin
                    // acc tracks "every probed bit was already set" = key present.
                    acc_d = acc_q & probe_bit;
                    if (op_q == OP_INSERT) begin
                        filter_d[idx_q] = 1'b1;
`ifdef IBEX_BLOOM_POPCOUNT_EN
                        if (!probe_bit) pc_d = pc_q + 16'd1;
`endif
                    end
                    // Power-of-2 width gives the mod-FilterBits wrap for free.
                    idx_d = idx_q + h2_q;
                    k_d   = k_q + KW'(1);
                    if (k_q == KLast) begin
                        state_d = ST_DONE;
                        if (op_q == OP_INSERT && cnt_q != '1) cnt_d = cnt_q + 32'd1;
                    end
                end
            end

            ST_CLEAR: begin
                filter_d[clr_base +: ClearPerCycle] = '0;
                ptr_d = ptr_q + PtrW'(1);
                // The sweep must finish to leave the array consistent; only the pulse is dropped.
                if (bus.kill_i) kill_seen_d = 1'b1;
                if (ptr_q == PtrLast) state_d = ST_DONE;
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_INSERT;
            idx_q       <= '0;
            h2_q        <= '0;
            k_q         <= '0;
            acc_q       <= 1'b0;
            ptr_q       <= '0;
            kill_seen_q <= 1'b0;
            cnt_q       <= '0;
            // NOTE: the filter array is plain flops, not a RAM macro, so it is reset with the rest of the state.
            filter_q    <= '0;
`ifdef IBEX_BLOOM_POPCOUNT_EN
            pc_q        <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values together.
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            h2_q        <= h2_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            ptr_q       <= ptr_d;
            kill_seen_q <= kill_seen_d;
            cnt_q       <= cnt_d;
            filter_q    <= filter_d;
`ifdef IBEX_BLOOM_POPCOUNT_EN
            pc_q        <= pc_d;
`endif
        end
    end

    always_comb begin
        result = '0;
        unique case (op_q)
            OP_INSERT, OP_CHECK: result = {31'b0, acc_q};
            OP_CLEAR:            result = '0;
`ifdef IBEX_BLOOM_POPCOUNT_EN
            OP_COUNT:            result = {pc_q, (|cnt_q[31:16]) ? 16'hFFFF : cnt_q[15:0]};
`else
            OP_COUNT:            result = cnt_q;
`endif
            default:             result = '0;
        endcase
    end

    assign bus.ready_o  = (state_q == ST_IDLE);
    assign bus.busy_o   = ~bus.ready_o;
    assign bus.valid_o  = (state_q == ST_DONE) & ~bus.kill_i & ~kill_seen_q;
    assign bus.result_o = bus.valid_o ? result : 32'd0;

endmodule

// File: doc/ibex_bloom_unit.md
Name: ibex_bloom_unit

Overview:
- Multi-cycle custom-instruction functional unit, instantiated inside the execute stage.
- Consumes the custom-op request (rs1/rs2 operands plus opcode) and holds a FilterBits-wide Bloom filter bit array.
- Supports insert, membership check, clear and count.
- Returns a 32-bit result with a single-cycle valid pulse; the execute stage muxes this into its result and stalls on it exactly as it does for multdiv.

Parameters:
- FilterBits, 1024: filter array size in bits; power of 2, range 64..4096.
- NumHashes, 3: probe indices per key; range 1..8.
- ClearPerCycle, 32: bits zeroed per cycle during CLEAR; power of 2, divides FilterBits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  request strobe; accepted only when ready_o=1
- op_i  in  2  bloom_op_e: 0 INSERT, 1 CHECK, 2 CLEAR, 3 COUNT
- key_a_i  in  32  rs1 operand
- key_b_i  in  32  rs2 operand
- kill_i  in  1  pipeline flush from controller
- ready_o  out  1  unit idle, can accept
- valid_o  out  1  one-cycle result pulse
- result_o  out  32  result, valid only with valid_o
- busy_o  out  1  ~ready_o

Behaviour:
- Reset: all outputs 0, except ready_o=1. State IDLE. Bit array all 0. insert_cnt=0.
- FSM states:
  - IDLE: ready_o=1. On req_i at cycle T, capture op, h1 and h2.
    - INSERT/CHECK -> HASH (k=0, idx=h1, acc=1).
    - CLEAR -> CLEAR (ptr=0).
    - COUNT -> DONE.
  - HASH: one probe per cycle.
    - acc &= bit[idx]. INSERT additionally sets bit[idx]<=1.
    - idx <= (idx+h2) mod FilterBits; k++.
    - k==NumHashes-1 -> DONE.
  - CLEAR: zero bits [ptr*ClearPerCycle +: ClearPerCycle]; ptr++. Last chunk -> DONE. insert_cnt<=0 on entry.
  - DONE: valid_o=1 for one cycle, then -> IDLE. ready_o=0 in DONE.
- Hash (combinational, from captured operands):
  - h1 = key_a ^ {key_b[15:0], key_b[31:16]}
  - h2 = (key_b ^ rotl(key_a,7)) | 1
  - Indices use the low log2(FilterBits) bits.
- Latency from accept at T:
  - INSERT/CHECK: valid at T+NumHashes+1.
  - CLEAR: valid at T+FilterBits/ClearPerCycle+1.
  - COUNT: valid at T+1.
- Results:
  - CHECK: {31'b0, acc}.
  - INSERT: {31'b0, acc}, i.e. key was already present. insert_cnt increments, saturating at 0xFFFF_FFFF.
  - CLEAR: 0.
  - COUNT: insert_cnt.
- req_i while ready_o=0 is ignored; the requester holds req_i.
- Same-index repeat within one INSERT: a later probe reads the bit as already set. The write is visible to the next probe cycle.
- kill_i:
  - In HASH: -> IDLE next cycle, no valid_o. Bits already set stay set; insert_cnt unchanged.
  - In DONE: suppresses valid_o.
  - In CLEAR: ignored; the clear completes, but valid_o is suppressed if kill was seen.
  - In IDLE: blocks acceptance that cycle.
- rst_i mid-operation: immediate return to reset state, array cleared, no valid_o.

Optional Feature:
- Macro: IBEX_BLOOM_POPCOUNT_EN.
- Defined:
  - A 16-bit occupancy counter pc_q increments whenever INSERT writes a bit that was 0. CLEAR zeroes it; reset zeroes it.
  - COUNT returns {pc_q, insert_cnt saturated to 16 bits}.
- Undefined: no pc_q logic; COUNT returns the 32-bit insert_cnt.

Decomposition:
- ibex_pkg gains:
  - bloom_op_e (2-bit enum)
  - bloom_state_e (IDLE, HASH, CLEAR, DONE)
  - BLOOM_ROT = 7
- Sub-module ibex_bloom_hash: combinational h1/h2 from key_a/key_b, parameterised on FilterBits.

Test Plan:
- INSERT a=0x1, b=0x0 (indices 1, 130, 259) at T -> valid_o at T+4, result 0; bits 1, 130, 259 set.
- CHECK a=0x1, b=0x0 after that insert -> result 1. CHECK a=0x2, b=0x0 (indices 2, 259, 516) -> result 0.
- Two INSERTs, then COUNT -> valid at T+1, result 2 (with POPCOUNT_EN: 0x0006_0002 for disjoint index sets, e.g. keys (1,0) and (5,0)).
- CLEAR at T -> valid at T+33; a subsequent CHECK a=0x1, b=0x0 -> 0; COUNT -> 0.
- INSERT with kill_i at T+2 -> no valid_o, ready_o at T+3, bit 1 set, COUNT unchanged.
- rst_i pulsed during CLEAR at ptr=10 -> ready_o=1, valid_o=0 immediately, all CHECKs return 0.
